reg_file_mp: RTL and testbench

- Parametrised successor to the single-write CPU register file, for the pipelined core.
- Provides NRD asynchronous read ports and two write-back ports with fixed priority.
- Adds a per-register busy scoreboard: decode sets busy bits, write-back clears them, so hazard logic can stall on pending producers.
- Register 0 is hardwired to zero and is never busy.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/reg_file_mp_scoreboard.sv | 58 +++++
 rtl/reg_file_mp.sv | 93 +++++++++
 tb/tb_reg_file_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default architectural sizes, register address
// type and the hardwired-zero register index.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits for hazard detection.
// Issue sets a bit, write-back clears it, and set wins over clear on the same
// register because the newly issued producer supersedes the one retiring.
// Also keeps a registered popcount of the busy vector.
module reg_scoreboard #(
    parameter  int NREG = cpu_pkg::NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            res,
    input  logic            clr0_i,
    input  logic [AW-1:0]   clr0_addr_i,
    input  logic            clr1_i,
    input  logic [AW-1:0]   clr1_addr_i,
    input  logic            set_i,
    input  logic [AW-1:0]   set_addr_i,
    output logic [NREG-1:0] busy_o,
    output logic [AW:0]     pend_cnt_o
);
    import cpu_pkg::REG_ZERO;

    logic [NREG-1:0] busy_q, busy_d;
    logic [AW:0]     cnt_q, cnt_d;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] n;
        n = '0;
        for (int i = 0; i < NREG; i++) begin
            n = n + (AW+1)'(v[i]);
        end
        return n;
    endfunction

    // Next busy vector: clears first, then set overrides; x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr0_i && (clr0_addr_i != AW'(REG_ZERO))) busy_d[clr0_addr_i] = 1'b0;
        if (clr1_i && (clr1_addr_i != AW'(REG_ZERO))) busy_d[clr1_addr_i] = 1'b0;
        if (set_i  && (set_addr_i  != AW'(REG_ZERO))) busy_d[set_addr_i]  = 1'b1;
        busy_d[0] = 1'b0;
        cnt_d     = popcount(busy_d);
    end

    // Busy vector and its count update together, so the count never lags.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the pipelined core.
// NRD combinational read ports, two write-back ports (port 1 wins on a
// shared address), x0 hardwired to zero, and a busy scoreboard.
// Optional macro REG_FILE_BYPASS_EN: write-first forwarding of same-cycle
// write-back data (and post-edge busy) onto matching read ports.
module reg_file_mp #(
    parameter  int XLEN = cpu_pkg::XLEN,
    parameter  int NREG = cpu_pkg::NREG,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [XLEN-1:0]   wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [XLEN-1:0]   wd1,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_rd,
    output logic [AW:0]       pend_cnt
);
    import cpu_pkg::REG_ZERO;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;
    logic            wr0_en, wr1_en;

    assign wr0_en = we0 && (wa0 != AW'(REG_ZERO));
    assign wr1_en = we1 && (wa1 != AW'(REG_ZERO));

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk        (clk),
        .res        (res),
        .clr0_i     (we0),
        .clr0_addr_i(wa0),
        .clr1_i     (we1),
        .clr1_addr_i(wa1),
        .set_i      (iss_v),
        .set_addr_i (iss_rd),
        .busy_o     (busy),
        .pend_cnt_o (pend_cnt)
    );

    // Next storage contents: port 1 applied last so it wins a shared address.
    always_comb begin
        regs_d = regs_q;
        if (wr0_en) regs_d[wa0] = wd0;
        if (wr1_en) regs_d[wa1] = wd1;
    end

    // Storage array; reset clears every register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rdata;
        logic            rbusy;

        assign addr = ra[p*AW +: AW];

        // Read mux for one port, with optional write-first forwarding.
        always_comb begin
            rdata = (addr == AW'(REG_ZERO)) ? '0 : regs_q[addr];
            rbusy = busy[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wr0_en && (wa0 == addr)) begin
                rdata = wd0;
                rbusy = iss_v && (iss_rd == addr);
            end
            if (wr1_en && (wa1 == addr)) begin
                rdata = wd1;
                rbusy = iss_v && (iss_rd == addr);
            end
`endif
        end

        assign rd[p*XLEN +: XLEN] = rdata;
        assign rd_busy[p]         = rbusy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp: directed scenarios followed by randomized
// traffic, checked against an array-based reference model of the register
// file and its busy scoreboard.
module tb_reg_file_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 res;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic [NRD-1:0]       rd_busy;
    logic                 we0, we1, iss_v;
    logic [AW-1:0]        wa0, wa1, iss_rd;
    logic [XLEN-1:0]      wd0, wd1;
    logic [AW:0]          pend_cnt;

    int tests = 0;
    int fails = 0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mbusy [NREG];

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk     (clk),
        .res     (res),
        .ra      (ra),
        .rd      (rd),
        .rd_busy (rd_busy),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .iss_v   (iss_v),
        .iss_rd  (iss_rd),
        .pend_cnt(pend_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pend();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic model_edge();
        if (we0 && wa0 != 0) begin mreg[wa0] = wd0; mbusy[wa0] = 1'b0; end
        if (we1 && wa1 != 0) begin mreg[wa1] = wd1; mbusy[wa1] = 1'b0; end
        if (iss_v && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    endtask

    task automatic check_model();
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] ed;
            logic            eb;
            a  = ra[p*AW +: AW];
            ed = (a == 0) ? '0 : mreg[a];
            eb = (a == 0) ? 1'b0 : mbusy[a];
`ifdef REG_FILE_BYPASS_EN
            if (a != 0 && ((we0 && wa0 == a) || (we1 && wa1 == a))) begin
                ed = (we1 && wa1 == a) ? wd1 : wd0;
                eb = iss_v && (iss_rd == a);
            end
`endif
            chk($sformatf("model_rd%0d_a%0d", p, a), 64'(rd[p*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("model_busy%0d_a%0d", p, a), 64'(rd_busy[p]), 64'(eb));
        end
        chk("model_pend", 64'(pend_cnt), 64'(model_pend()));
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        iss_v = 1'b0; iss_rd = '0;
    endtask

    // Move to mid-cycle and compare combinational outputs with the model.
    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    // Advance through one rising edge.
    task automatic step();
        @(posedge clk);
        if (res) model_edge();
        #1;
    endtask

    initial begin
        res = 1'b0;
        idle();
        ra = {5'd0, 5'd5};
        model_reset();

        // Reset held low for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd", 64'(rd), 64'd0);
        chk("reset_busy", 64'(rd_busy), 64'd0);
        chk("reset_pend", 64'(pend_cnt), 64'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        settle(); step();

        // Basic write / read.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'd42;
        settle(); step();
        wa0 = 5'd10; wd0 = 32'd100;
        settle(); step();
        idle(); ra = {5'd5, 5'd10};
        settle();
        chk("basic_rd0", 64'(rd[31:0]), 64'd100);
        chk("basic_rd1", 64'(rd[63:32]), 64'd42);
        step();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd2; ra = '0;
        settle(); step();
        idle();
        settle();
        chk("x0_read", 64'(rd[31:0]), 64'd0);
        step();

        // Dual-write collision and distinct addresses.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
        settle(); step();
        idle(); ra = {5'd0, 5'd7};
        settle();
        chk("collide_rd", 64'(rd[31:0]), 64'h22);
        step();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hB;
        settle(); step();
        idle(); ra = {5'd4, 5'd3};
        settle();
        chk("distinct_rd0", 64'(rd[31:0]), 64'hA);
        chk("distinct_rd1", 64'(rd[63:32]), 64'hB);
        step();

        // Scoreboard set / clear / set-wins / issue to x0.
        iss_v = 1'b1; iss_rd = 5'd6; ra = {5'd0, 5'd6};
        settle(); step();
        idle();
        settle();
        chk("sb_set_busy", 64'(rd_busy[0]), 64'd1);
        chk("sb_set_pend", 64'(pend_cnt), 64'd1);
        step();
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66;
        settle(); step();
        idle();
        settle();
        chk("sb_clr_busy", 64'(rd_busy[0]), 64'd0);
        chk("sb_clr_pend", 64'(pend_cnt), 64'd0);
        step();
        iss_v = 1'b1; iss_rd = 5'd6; we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h77;
        settle(); step();
        idle();
        settle();
        chk("sb_setwins_busy", 64'(rd_busy[0]), 64'd1);
        chk("sb_setwins_pend", 64'(pend_cnt), 64'd1);
        step();
        iss_v = 1'b1; iss_rd = 5'd0;
        settle(); step();
        idle();
        settle();
        chk("sb_x0_pend", 64'(pend_cnt), 64'd1);
        step();

        // Same-cycle read of a register being written.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h33;
        settle(); step();
        idle(); we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h55; ra = {5'd0, 5'd9};
        settle();
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_same", 64'(rd[31:0]), 64'h55);
`else
        chk("bypass_same", 64'(rd[31:0]), 64'h33);
`endif
        step();
        idle();
        settle();
        chk("bypass_next", 64'(rd[31:0]), 64'h55);
        step();

        // Asynchronous reset between edges.
        we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h2;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h3;
        settle(); step();
        idle(); iss_v = 1'b1; iss_rd = 5'd2;
        settle(); step();
        iss_rd = 5'd3;
        settle(); step();
        idle(); ra = {5'd3, 5'd2};
        settle();
        chk("prerst_busy", 64'(rd_busy), 64'h3);
        chk("prerst_pend", 64'(pend_cnt), 64'd3);
        #2;
        res = 1'b0;
        #1;
        model_reset();
        chk("async_rd", 64'(rd), 64'd0);
        chk("async_busy", 64'(rd_busy), 64'd0);
        chk("async_pend", 64'(pend_cnt), 64'd0);
        @(posedge clk);
        #1;
        res = 1'b1;
        settle(); step();

        // Randomized traffic against the model.
        repeat (400) begin
            we0    = 1'($urandom_range(0, 1));
            wa0    = AW'($urandom_range(0, 11));
            wd0    = $urandom;
            we1    = 1'($urandom_range(0, 1));
            wa1    = AW'($urandom_range(0, 11));
            wd1    = $urandom;
            iss_v  = 1'($urandom_range(0, 1));
            iss_rd = AW'($urandom_range(0, 11));
            ra     = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
            settle(); step();
        end
        idle();
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
